// File: rtl/wide_add_seq_if.sv
// Requester, response and shared-adder signals of wide_add_seq.
// The slave modport is the sequencer; the master modport is its environment.
interface wide_add_seq_if #(
   parameter int unsigned WORDS = 4
);
   localparam int unsigned W = 16 * WORDS;

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_sub;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_sub;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         rsp_ovf;
   logic         rsp_id;

   logic [15:0]  add_a;
   logic [15:0]  add_b;
   logic         add_cin;
   logic [15:0]  add_s;
   logic         add_cout;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sub,
      output req1_ready,
      output rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id,
      input  rsp_ready,
      output add_a, add_b, add_cin,
      input  add_s, add_cout
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sub,
      input  req1_ready,
      input  rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id,
      output rsp_ready,
      input  add_a, add_b, add_cin,
      output add_s, add_cout
   );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: two requesters share one external 16-bit adder,
// processing one beat per cycle, LSB beat first, with the carry chained through a register.
module wide_add_seq #(
   parameter int unsigned WORDS = 4
) (
   input logic           clk,
   input logic           rst,
   wide_add_seq_if.slave bus
);
   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned KW = $clog2(WORDS);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]    state_q;
   logic [KW-1:0] k_q;
   logic          carry_q;
   logic          last_grant_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          sub_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          ovf_q;
   logic          id_q;

   logic          gnt0;
   logic          gnt1;
   logic          acc0;
   logic          acc1;
   logic          last_beat;
   logic [15:0]   a_beat;
   logic [15:0]   b_beat;

   // On a tie the requester not served last wins; last_grant resets to 1 so req0 wins first.
   always_comb begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
   end

   assign bus.req0_ready = (state_q == StIdle) && gnt0 && !rst;
   assign bus.req1_ready = (state_q == StIdle) && gnt1 && !rst;
   assign acc0           = bus.req0_valid && bus.req0_ready;
   assign acc1           = bus.req1_valid && bus.req1_ready;

   always_comb begin
      a_beat = a_q[{k_q, 4'b0000} +: 16];
      b_beat = b_q[{k_q, 4'b0000} +: 16];
      if (sub_q) begin
         b_beat = ~b_beat;
      end
   end

   assign last_beat = (k_q == KW'(WORDS - 1));

   always_comb begin
      bus.add_a   = '0;
      bus.add_b   = '0;
      bus.add_cin = 1'b0;
      if (state_q == StRun) begin
         bus.add_a   = a_beat;
         bus.add_b   = b_beat;
         bus.add_cin = (k_q == '0) ? sub_q : carry_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         k_q          <= '0;
         carry_q      <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         sub_q        <= 1'b0;
         sum_q        <= '0;
         cout_q       <= 1'b0;
         ovf_q        <= 1'b0;
         id_q         <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (acc0 || acc1) begin
                  a_q          <= acc0 ? bus.req0_a : bus.req1_a;
                  b_q          <= acc0 ? bus.req0_b : bus.req1_b;
                  sub_q        <= acc0 ? bus.req0_sub : bus.req1_sub;
                  id_q         <= acc1;
                  last_grant_q <= acc1;
                  k_q          <= '0;
                  state_q      <= StRun;
               end
            end
            StRun: begin
               sum_q[{k_q, 4'b0000} +: 16] <= bus.add_s;
               carry_q                     <= bus.add_cout;
               if (last_beat) begin
                  cout_q  <= bus.add_cout;
                  // Signed overflow: operands agree in sign but the result does not.
                  ovf_q   <= (a_beat[15] == b_beat[15]) && (bus.add_s[15] != a_beat[15]);
                  state_q <= StDone;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            StDone: begin
               if (bus.rsp_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rsp_valid = (state_q == StDone);
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.rsp_ovf   = ovf_q;
   assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS = 4) with a behavioural 16-bit adder slice.
module tb_wide_add_seq;
   localparam int unsigned WORDS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wide_add_seq_if #(.WORDS(WORDS)) bus ();

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign {bus.add_cout, bus.add_s} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        id;
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic sub);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
      end
   endtask

   // Issue one op, wait for its response and take it; lat counts cycles after the accept edge.
   task automatic do_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, output logic [63:0] sum, output logic cout,
                        output logic ovf, output logic rid, output logic cin0,
                        output int lat);
      logic acc;
      acc = 1'b0;
      sum = '0; cout = 1'b0; ovf = 1'b0; rid = 1'b0; cin0 = 1'b0; lat = -1;
      @(negedge clk);
      drive(id, a, b, sub);
      for (int i = 0; i < 20; i++) begin
         #1;
         acc = id ? bus.req1_ready : bus.req0_ready;
         if (acc) break;
         @(negedge clk);
      end
      if (!acc) begin
         check("accept seen", acc, 1);
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      cin0 = bus.add_cin;
      lat  = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.rsp_valid) begin
         check("rsp_valid seen", bus.rsp_valid, 1);
         return;
      end
      sum  = bus.rsp_sum;
      cout = bus.rsp_cout;
      ovf  = bus.rsp_ovf;
      rid  = bus.rsp_id;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] s;
      logic        c, o, id, cin0;
      int          lat;
      int          cyc;
      int          g_cyc[$];
      logic        g_id[$];
      logic        r_id[$];
      logic [63:0] r_sum[$];
      logic        seen;

      vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000,
                  1'b0, 1'b1};
      vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
                  1'b1, 1'b1};
      vecs[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0,
                  1'b1, 1'b1};

      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
      bus.rsp_ready  = 1'b0;

      // Reset state, with a requester valid to confirm ready stays low under reset.
      rst = 1'b1;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst req0_ready", bus.req0_ready, 0);
      check("rst rsp_valid", bus.rsp_valid, 0);
      check("rst rsp_sum", bus.rsp_sum, 0);
      check("rst add_a", bus.add_a, 0);
      bus.req0_valid = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, s, c, o, id, cin0, lat);
         check($sformatf("v%0d sum", i), s, vecs[i].sum);
         check($sformatf("v%0d cout", i), c, vecs[i].cout);
         check($sformatf("v%0d ovf", i), o, vecs[i].ovf);
         check($sformatf("v%0d id", i), id, vecs[i].id);
         check($sformatf("v%0d latency", i), lat, 5);
         check($sformatf("v%0d beat0 cin", i), cin0, vecs[i].sub);
         check($sformatf("v%0d idle add_b", i), bus.add_b, 0);
      end

      // Fairness: both valid continuously, rsp_ready tied high.
      do_reset();
      drive(1'b0, 64'd1, 64'd1, 1'b0);
      drive(1'b1, 64'd5, 64'd2, 1'b1);
      bus.rsp_ready = 1'b1;
      cyc = 0;
      while (r_id.size() < 6 && cyc < 100) begin
         #1;
         if (g_id.size() < 6 && bus.req0_ready) begin g_id.push_back(1'b0); g_cyc.push_back(cyc); end
         if (g_id.size() < 6 && bus.req1_ready) begin g_id.push_back(1'b1); g_cyc.push_back(cyc); end
         if (bus.rsp_valid) begin r_id.push_back(bus.rsp_id); r_sum.push_back(bus.rsp_sum); end
         @(negedge clk);
         cyc++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b0;
      check("fair grants", g_id.size(), 6);
      check("fair responses", r_id.size(), 6);
      for (int i = 0; i < g_id.size(); i++) begin
         check($sformatf("fair grant %0d", i), g_id[i], (i % 2 == 1));
         if (i > 0) check($sformatf("fair spacing %0d", i), g_cyc[i] - g_cyc[i-1], 6);
      end
      for (int i = 0; i < r_id.size(); i++) begin
         check($sformatf("fair rsp_id %0d", i), r_id[i], (i % 2 == 1));
         check($sformatf("fair sum %0d", i), r_sum[i], (i % 2 == 1) ? 64'd3 : 64'd2);
      end

      // Backpressure: req1 valid throughout while req0's response is held off.
      do_reset();
      @(negedge clk);
      drive(1'b0, 64'd3, 64'd4, 1'b0);
      drive(1'b1, 64'd10, 64'd4, 1'b1);
      #1;
      check("bp tie req0_ready", bus.req0_ready, 1);
      check("bp tie req1_ready", bus.req1_ready, 0);
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         check($sformatf("bp run req1_ready c%0d", lat), bus.req1_ready, 0);
         @(negedge clk);
         lat++;
      end
      check("bp latency", lat, 5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp hold valid %0d", i), bus.rsp_valid, 1);
         check($sformatf("bp hold sum %0d", i), bus.rsp_sum, 64'd7);
         check($sformatf("bp hold id %0d", i), bus.rsp_id, 0);
         check($sformatf("bp hold cout %0d", i), bus.rsp_cout, 0);
         check($sformatf("bp req1_ready %0d", i), bus.req1_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("bp req1 ready after take", bus.req1_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("bp req1 sum", bus.rsp_sum, 64'd6);
      check("bp req1 id", bus.rsp_id, 1);
      check("bp req1 cout", bus.rsp_cout, 1);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;

      // Reset during beat 2 of a carry-rippling add.
      @(negedge clk);
      drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      #1;
      check("mid accept ready", bus.req0_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid beat2 add_a", bus.add_a, 16'hFFFF);
      check("mid beat2 add_cin", bus.add_cin, 1);
      rst = 1'b1;
      #1;
      check("mid rst add_a", bus.add_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid rel rsp_valid", bus.rsp_valid, 0);
      check("mid rel rsp_sum", bus.rsp_sum, 0);
      check("mid rel rsp_cout", bus.rsp_cout, 0);
      check("mid rel rsp_ovf", bus.rsp_ovf, 0);
      check("mid rel rsp_id", bus.rsp_id, 0);
      check("mid rel add_cin", bus.add_cin, 0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | bus.rsp_valid;
      end
      check("mid no response", seen, 0);
      do_op(1'b0, 64'd3, 64'd4, 1'b0, s, c, o, id, cin0, lat);
      check("mid new sum", s, 64'd7);
      check("mid new id", id, 0);
      check("mid new cout", c, 0);
      check("mid new latency", lat, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
